uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver: oversampled start/data/parity/stop decode feeding a first-word-fall-through FIFO.
// Sticky frame/parity/overrun flags; read_int is high while the FIFO holds data.
//
// state   | meaning
// S_IDLE  | line idle, waiting for a synced 1->0 edge
// S_START | timing to start-bit centre, rejects glitches
// S_DATA  | sampling DATA_BITS data bits, LSB first
// S_PAR   | sampling the parity bit (PARITY != 0 only)
// S_STOP  | sampling STOP_BITS stop bits, frame verdict on the last one
// S_BRK   | stop bit was 0, waiting for the line to return high
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          uart_in,
   output logic [DATA_BITS-1:0]          uart_to_cpu_buf,
   output logic                          read_int,
   input  logic                          cpu_end_read,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   input  logic                          err_clear
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] HALF_M1   = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] FULL_M1   = TW'(CLKS_PER_BIT - 1);
   localparam logic [TW-1:0] T_ONE     = TW'(1);
   localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
   localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
   localparam logic [PW:0]   DEPTH     = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]   C_ONE     = (PW+1)'(1);
   localparam logic [PW-1:0] P_ONE     = PW'(1);
   localparam logic          ODD       = (PARITY == 2);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_BRK   = 3'd5;

   logic                 sync1, sync2, rx_prev, rx_s, cer_prev;
   logic [1:0]           settle;
   logic [2:0]           state;
   logic [TW-1:0]        cnt;
   logic [3:0]           bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 par_bad, stop_bad;
   logic                 tick, start_det, frame_end, stop_bad_now;
   logic                 push, pop, push_ok, full;
   logic [PW-1:0]        wr_ptr, rd_ptr, rd_ptr_nx;
   logic [PW:0]          count_nx;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

   assign rx_s         = sync2;
   assign tick         = (cnt == '0);
   // settle blocks the preset-1 synchroniser from faking an edge right after reset
   assign start_det    = (state == S_IDLE) && (settle == 2'd3) && rx_prev && !rx_s;
   assign frame_end    = (state == S_STOP) && tick && (bit_idx == LAST_STOP);
   assign stop_bad_now = stop_bad | ~rx_s;
   assign push         = frame_end && !stop_bad_now && !par_bad;
   assign full         = (fifo_count == DEPTH);
   assign pop          = cpu_end_read && !cer_prev && (fifo_count != '0);
   assign push_ok      = push && (!full || pop);
   assign rd_ptr_nx    = rd_ptr + P_ONE;

   always_comb begin
      count_nx = fifo_count;
      if (push_ok && !pop)
         count_nx = fifo_count + C_ONE;
      else if (pop && !push_ok)
         count_nx = fifo_count - C_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         rx_prev <= 1'b1;
         settle  <= 2'd0;
      end else begin
         sync1   <= uart_in;
         sync2   <= sync1;
         rx_prev <= sync2;
         if (settle != 2'd3)
            settle <= settle + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_bad  <= 1'b0;
         stop_bad <= 1'b0;
      end else begin
         if (state != S_IDLE && state != S_BRK)
            cnt <= tick ? FULL_M1 : cnt - T_ONE;
         case (state)
            S_IDLE: begin
               if (start_det) begin
                  state <= S_START;
                  cnt   <= HALF_M1;
               end
            end
            S_START: begin
               if (tick) begin
                  bit_idx <= '0;
                  state   <= rx_s ? S_IDLE : S_DATA;
               end
            end
            S_DATA: begin
               if (tick) begin
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_idx == LAST_DATA) begin
                     bit_idx  <= '0;
                     par_bad  <= 1'b0;
                     stop_bad <= 1'b0;
                     state    <= (PARITY != 0) ? S_PAR : S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            S_PAR: begin
               if (tick) begin
                  par_bad <= ((^shreg) ^ rx_s) != ODD;
                  state   <= S_STOP;
               end
            end
            S_STOP: begin
               if (tick) begin
                  stop_bad <= stop_bad_now;
                  if (bit_idx == LAST_STOP) begin
                     bit_idx <= '0;
                     state   <= stop_bad_now ? S_BRK : S_IDLE;
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                  end
               end
            end
            S_BRK: begin
               if (rx_s)
                  state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= shreg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         fifo_count      <= '0;
         read_int        <= 1'b0;
         uart_to_cpu_buf <= '0;
         cer_prev        <= 1'b0;
      end else begin
         cer_prev   <= cpu_end_read;
         fifo_count <= count_nx;
         read_int   <= (count_nx != '0);
         if (push_ok)
            wr_ptr <= wr_ptr + P_ONE;
         if (pop)
            rd_ptr <= rd_ptr_nx;
         // head comes from the incoming word when it becomes the only entry
         if (push_ok && (fifo_count == '0 || (pop && fifo_count == C_ONE)))
            uart_to_cpu_buf <= shreg;
         else if (pop && fifo_count > C_ONE)
            uart_to_cpu_buf <= mem[rd_ptr_nx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (frame_end && stop_bad_now)
            frame_err <= 1'b1;
         else if (err_clear)
            frame_err <= 1'b0;
         if (frame_end && par_bad)
            parity_err <= 1'b1;
         else if (err_clear)
            parity_err <= 1'b0;
         if (push && full && !pop)
            overrun <= 1'b1;
         else if (err_clear)
            overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 instance for most steps, an even-parity instance for parity steps.
module tb_uart_rx_fifo;
   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       uart_m = 1'b1, uart_p = 1'b1;
   logic       cer_m = 1'b0, cer_p = 1'b0;
   logic       clr_m = 1'b0, clr_p = 1'b0;
   logic [7:0] buf_m, buf_p;
   logic       int_m, int_p;
   logic [2:0] cnt_m, cnt_p;
   logic       fe_m, pe_m, ov_m, fe_p, pe_p, ov_p;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .uart_in(uart_m), .uart_to_cpu_buf(buf_m), .read_int(int_m),
      .cpu_end_read(cer_m), .fifo_count(cnt_m), .frame_err(fe_m), .parity_err(pe_m),
      .overrun(ov_m), .err_clear(clr_m));

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
      .clk(clk), .rst(rst), .uart_in(uart_p), .uart_to_cpu_buf(buf_p), .read_int(int_p),
      .cpu_end_read(cer_p), .fifo_count(cnt_p), .frame_err(fe_p), .parity_err(pe_p),
      .overrun(ov_p), .err_clear(clr_p));

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_assert++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // drives n bits LSB first, one bit period each, on the 8N1 line (sel=0) or parity line (sel=1)
   task automatic send_bits(input logic [15:0] bits, input int n, input bit sel);
      logic [15:0] b;
      b = bits;
      for (int i = 0; i < n; i++) begin
         if (sel) uart_p = b[i];
         else     uart_m = b[i];
         tick(CPB);
      end
   endtask

   task automatic send_8n1(input logic [7:0] d);
      send_bits({6'h3f, 1'b1, d, 1'b0}, 10, 1'b0);
   endtask

   task automatic pop_m(input int hold);
      cer_m = 1'b1;
      tick(hold);
      cer_m = 1'b0;
      tick(2);
   endtask

   initial begin
      tick(4);
      rst = 1'b0;
      tick(10);
      chk("rst_count", 16'(cnt_m), 16'd0);
      chk("rst_int", 16'(int_m), 16'd0);
      chk("rst_buf", 16'(buf_m), 16'h00);
      chk("rst_flags", 16'({fe_m, pe_m, ov_m}), 16'd0);

      // 1: 0xA5 8N1
      send_bits({6'h00, 1'b0, 8'hA5, 1'b0}, 9, 1'b0);
      chk("t1_int_before_stop", 16'(int_m), 16'd0);
      uart_m = 1'b1;
      tick(CPB);
      tick(2);
      chk("t1_int", 16'(int_m), 16'd1);
      chk("t1_buf", 16'(buf_m), 16'hA5);
      chk("t1_count", 16'(cnt_m), 16'd1);
      pop_m(3);
      chk("t1_pop_int", 16'(int_m), 16'd0);
      chk("t1_pop_count", 16'(cnt_m), 16'd0);
      chk("t1_buf_hold", 16'(buf_m), 16'hA5);
      pop_m(1);
      chk("t1_pop_empty", 16'(cnt_m), 16'd0);

      // 2: short low glitch
      uart_m = 1'b0;
      tick(4);
      uart_m = 1'b1;
      tick(3 * CPB);
      chk("t2_count", 16'(cnt_m), 16'd0);
      chk("t2_flags", 16'({fe_m, pe_m, ov_m}), 16'd0);

      // 3: five frames back-to-back into a 4-deep FIFO
      for (int k = 1; k <= 5; k++)
         send_8n1(8'(k));
      tick(20);
      chk("t3_count", 16'(cnt_m), 16'd4);
      chk("t3_overrun", 16'(ov_m), 16'd1);
      chk("t3_int", 16'(int_m), 16'd1);
      chk("t3_frame_err", 16'(fe_m), 16'd0);
      chk("t3_head1", 16'(buf_m), 16'h01);
      pop_m(4);
      chk("t3_count_hold_pop", 16'(cnt_m), 16'd3);
      chk("t3_head2", 16'(buf_m), 16'h02);
      pop_m(1);
      chk("t3_head3", 16'(buf_m), 16'h03);
      pop_m(1);
      chk("t3_head4", 16'(buf_m), 16'h04);
      pop_m(1);
      chk("t3_empty", 16'(cnt_m), 16'd0);
      chk("t3_empty_int", 16'(int_m), 16'd0);

      // 4: stop bit 0 with line held low, then a clean frame
      send_bits({6'h00, 1'b0, 8'h3C, 1'b0}, 10, 1'b0);
      tick(24);
      chk("t4_frame_err", 16'(fe_m), 16'd1);
      chk("t4_count", 16'(cnt_m), 16'd0);
      uart_m = 1'b1;
      tick(40);
      send_8n1(8'h42);
      tick(4);
      chk("t4_buf", 16'(buf_m), 16'h42);
      chk("t4_count2", 16'(cnt_m), 16'd1);
      chk("t4_frame_err_sticky", 16'(fe_m), 16'd1);

      // 5: even parity instance
      send_bits({5'h1f, 1'b1, 1'b1, 8'h03, 1'b0}, 11, 1'b1);
      tick(4);
      chk("t5_parity_err", 16'(pe_p), 16'd1);
      chk("t5_count", 16'(cnt_p), 16'd0);
      chk("t5_frame_err", 16'(fe_p), 16'd0);
      send_bits({5'h1f, 1'b1, 1'b0, 8'h03, 1'b0}, 11, 1'b1);
      tick(4);
      chk("t5_buf", 16'(buf_p), 16'h03);
      chk("t5_count2", 16'(cnt_p), 16'd1);
      chk("t5_parity_sticky", 16'(pe_p), 16'd1);
      clr_p = 1'b1;
      tick(1);
      clr_p = 1'b0;
      tick(1);
      chk("t5_cleared", 16'(pe_p), 16'd0);

      // 6: reset mid-frame with two words queued and flags set
      send_8n1(8'h11);
      tick(4);
      chk("t6_count_pre", 16'(cnt_m), 16'd2);
      uart_m = 1'b0;
      tick(4 * CPB + CPB / 2);
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("t6_count", 16'(cnt_m), 16'd0);
      chk("t6_int", 16'(int_m), 16'd0);
      chk("t6_flags", 16'({fe_m, pe_m, ov_m}), 16'd0);
      chk("t6_buf", 16'(buf_m), 16'h00);
      tick(5);
      uart_m = 1'b1;
      tick(3 * CPB);
      chk("t6_no_false_start", 16'(cnt_m), 16'd0);
      send_8n1(8'h5A);
      tick(4);
      chk("t6_buf2", 16'(buf_m), 16'h5A);
      chk("t6_count2", 16'(cnt_m), 16'd1);
      chk("t6_flags2", 16'({fe_m, pe_m, ov_m}), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
